// File: rtl/arith_sequencer_if.sv
// arith_sequencer_if: bus between the sequencer and its environment.
//   run          - level request to execute instructions (to sequencer)
//   imem_req     - instruction fetch request (from sequencer)
//   imem_ready   - fetch data valid on inst this cycle (to sequencer)
//   inst         - 32-bit instruction word (to sequencer)
//   ir_load      - instruction register load strobe
//   pc_enable    - PC register load enable (PC+4)
//   rf_wr_enable - register file write enable
//   alu_op       - ALU operation select
//   alu_src2     - ALU operand B select: 1 = immediate, 0 = rt
//   rd_src       - write register select: 1 = rt, 0 = rd
//   zext         - immediate extension: 1 = zero-extend, 0 = sign-extend
//   except       - sticky unrecognized-instruction flag
//   busy         - high in every state except IDLE and HALT
//   retired      - count of completed instructions
// The slave modport is the sequencer's view; master is the environment's view.
interface arith_sequencer_if;
  logic        run;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] inst;
  logic        ir_load;
  logic        pc_enable;
  logic        rf_wr_enable;
  logic [2:0]  alu_op;
  logic        alu_src2;
  logic        rd_src;
  logic        zext;
  logic        except;
  logic        busy;
  logic [15:0] retired;

  modport master (
    output run, imem_ready, inst,
    input  imem_req, ir_load, pc_enable, rf_wr_enable, alu_op, alu_src2, rd_src, zext,
    input  except, busy, retired
  );

  modport slave (
    input  run, imem_ready, inst,
    output imem_req, ir_load, pc_enable, rf_wr_enable, alu_op, alu_src2, rd_src, zext,
    output except, busy, retired
  );
endinterface

// File: rtl/arith_sequencer.sv
// arith_sequencer: multi-cycle control sequencer for a small integer datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB; an unrecognised
// instruction parks the FSM in HALT with the sticky except flag set until reset.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - arith_sequencer_if.slave (fetch handshake, datapath controls, status)
module arith_sequencer (
  input  logic                    clock,
  input  logic                    reset,
  arith_sequencer_if.slave        bus
);

  // FSM encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  // ALU operation codes
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b011;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluOr  = 3'b101;
  localparam logic [2:0] AluNor = 3'b110;
  localparam logic [2:0] AluXor = 3'b111;

  // Opcodes and R-type function codes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;

  logic [2:0]  state_q, state_d;
  logic [5:0]  opcode_q, funct_q;
  logic [2:0]  alu_op_q;
  logic        alu_src2_q, rd_src_q, zext_q;
  logic        except_q;
  logic [15:0] retired_q;

  logic        fetch_done;
  logic        dec_legal;
  logic [2:0]  dec_alu_op;
  logic        dec_alu_src2, dec_rd_src, dec_zext;

  // Only the opcode and funct fields steer control; the register and
  // immediate fields go straight to the datapath.
  logic unused_inst;
  assign unused_inst = ^bus.inst[25:6];

  assign fetch_done = (state_q == StFetch) && bus.imem_ready;

  // Decode of the captured fields
  always_comb begin
    dec_legal    = 1'b1;
    dec_alu_op   = AluAdd;
    dec_alu_src2 = 1'b0;
    dec_rd_src   = 1'b0;
    dec_zext     = 1'b0;
    if (opcode_q == OpRtype) begin
      case (funct_q)
        FnAdd:   dec_alu_op = AluAdd;
        FnSub:   dec_alu_op = AluSub;
        FnAnd:   dec_alu_op = AluAnd;
        FnOr:    dec_alu_op = AluOr;
        FnXor:   dec_alu_op = AluXor;
        FnNor:   dec_alu_op = AluNor;
        default: dec_legal  = 1'b0;
      endcase
    end else begin
      // I-type: immediate operand, result goes to rt
      dec_alu_src2 = 1'b1;
      dec_rd_src   = 1'b1;
      case (opcode_q)
        OpAddi: dec_alu_op = AluAdd;
        OpAndi: begin
          dec_alu_op = AluAnd;
          dec_zext   = 1'b1;
        end
        OpOri: begin
          dec_alu_op = AluOr;
          dec_zext   = 1'b1;
        end
        OpXori: begin
          dec_alu_op = AluXor;
          dec_zext   = 1'b1;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.run) state_d = StFetch;
      StFetch:  if (bus.imem_ready) state_d = StDecode;
      StDecode: state_d = dec_legal ? StExec : StHalt;
      StExec:   state_d = StWb;
      // run is only sampled here, so dropping it mid-instruction never aborts it
      StWb:     state_d = bus.run ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction field capture on the fetch handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_q <= 6'h00;
      funct_q  <= 6'h00;
    end else if (fetch_done) begin
      opcode_q <= bus.inst[31:26];
      funct_q  <= bus.inst[5:0];
    end
  end

  // Datapath controls latch leaving DECODE and stay stable through EXEC and WB.
  // An illegal instruction leaves them untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_op_q   <= AluAdd;
      alu_src2_q <= 1'b0;
      rd_src_q   <= 1'b0;
      zext_q     <= 1'b0;
    end else if ((state_q == StDecode) && dec_legal) begin
      alu_op_q   <= dec_alu_op;
      alu_src2_q <= dec_alu_src2;
      rd_src_q   <= dec_rd_src;
      zext_q     <= dec_zext;
    end
  end

  // Sticky illegal-instruction flag, set on the transition into HALT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      except_q <= 1'b0;
    end else if ((state_q == StDecode) && !dec_legal) begin
      except_q <= 1'b1;
    end
  end

  // Retired-instruction counter; wraps silently
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= 16'h0000;
    end else if (state_q == StWb) begin
      retired_q <= retired_q + 16'h0001;
    end
  end

  // Moore strobes (ir_load additionally qualified by imem_ready)
  assign bus.imem_req     = (state_q == StFetch);
  assign bus.ir_load      = fetch_done;
  assign bus.rf_wr_enable = (state_q == StWb);
  assign bus.pc_enable    = (state_q == StWb);
  assign bus.busy         = (state_q != StIdle) && (state_q != StHalt);

  assign bus.alu_op   = alu_op_q;
  assign bus.alu_src2 = alu_src2_q;
  assign bus.rd_src   = rd_src_q;
  assign bus.zext     = zext_q;
  assign bus.except   = except_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed self-checking bench for arith_sequencer. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_arith_sequencer;

  localparam logic [31:0] InstAdd  = 32'h0022_1820;
  localparam logic [31:0] InstSub  = 32'h0022_1822;
  localparam logic [31:0] InstXor  = 32'h0022_1826;
  localparam logic [31:0] InstOri  = 32'h3422_FFFF;
  localparam logic [31:0] InstAddi = 32'h2022_FFFF;
  localparam logic [31:0] InstLw   = 32'h8C22_0000;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  arith_sequencer_if bus ();

  arith_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.run        = 1'b0;
    bus.imem_ready = 1'b0;
    bus.inst       = 32'h0;
    repeat (2) @(negedge clock);

    // Reset state
    check_eq("rst_strobes", {bus.imem_req, bus.ir_load, bus.rf_wr_enable, bus.pc_enable}, 0);
    check_eq("rst_alu_op", bus.alu_op, 3'b010);
    check_eq("rst_ctrl", {bus.alu_src2, bus.rd_src, bus.zext}, 0);
    check_eq("rst_except", bus.except, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_retired", bus.retired, 0);

    // Idle with run low
    reset = 1'b1;
    @(negedge clock);
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_req", bus.imem_req, 0);

    // Back-to-back add with imem_ready always high: 4-cycle cadence
    bus.run        = 1'b1;
    bus.imem_ready = 1'b1;
    bus.inst       = InstAdd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      check_eq($sformatf("add_irload_c%0d", c), bus.ir_load, (c % 4 == 1));
      check_eq($sformatf("add_rfwr_c%0d", c), bus.rf_wr_enable, (c % 4 == 0));
      check_eq($sformatf("add_pcen_c%0d", c), bus.pc_enable, (c % 4 == 0));
      check_eq($sformatf("add_retired_c%0d", c), bus.retired, (c - 1) / 4);
      check_eq($sformatf("add_busy_c%0d", c), bus.busy, 1);
      if (c % 4 == 0) check_eq($sformatf("add_aluop_c%0d", c), bus.alu_op, 3'b010);
      if (c == 8) bus.inst = InstOri;
    end

    // ori: immediate, rt destination, zero-extend, or
    @(negedge clock);
    check_eq("ori_irload", bus.ir_load, 1);
    @(negedge clock);
    check_eq("ori_decode_busy", bus.busy, 1);
    @(negedge clock);
    check_eq("ori_exec_aluop", bus.alu_op, 3'b101);
    check_eq("ori_exec_ctrl", {bus.alu_src2, bus.rd_src, bus.zext}, 3'b111);
    check_eq("ori_exec_rfwr", bus.rf_wr_enable, 0);
    @(negedge clock);
    check_eq("ori_wb_aluop", bus.alu_op, 3'b101);
    check_eq("ori_wb_ctrl", {bus.alu_src2, bus.rd_src, bus.zext}, 3'b111);
    check_eq("ori_wb_rfwr", bus.rf_wr_enable, 1);
    bus.run = 1'b0;
    @(negedge clock);
    check_eq("ori_idle_busy", bus.busy, 0);
    check_eq("ori_retired", bus.retired, 3);

    // Fetch stall for 5 cycles, then xor; run dropped in DECODE
    bus.imem_ready = 1'b0;
    bus.inst       = InstXor;
    bus.run        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq($sformatf("stall_req_%0d", i), bus.imem_req, 1);
      check_eq($sformatf("stall_irload_%0d", i), bus.ir_load, 0);
    end
    bus.imem_ready = 1'b1;
    #1;
    check_eq("stall_irload_ready", bus.ir_load, 1);
    @(negedge clock);
    check_eq("xor_decode_strobes", {bus.imem_req, bus.ir_load}, 0);
    bus.run = 1'b0;
    @(negedge clock);
    check_eq("xor_exec_aluop", bus.alu_op, 3'b111);
    check_eq("xor_exec_ctrl", {bus.alu_src2, bus.rd_src}, 0);
    check_eq("xor_exec_busy", bus.busy, 1);
    @(negedge clock);
    check_eq("xor_wb_strobes", {bus.rf_wr_enable, bus.pc_enable}, 2'b11);
    @(negedge clock);
    check_eq("rundrop_idle_busy", bus.busy, 0);
    check_eq("rundrop_idle_req", bus.imem_req, 0);
    check_eq("rundrop_retired", bus.retired, 4);

    // Reset asserted in EXEC of a sub
    bus.inst = InstSub;
    bus.run  = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("sub_exec_aluop", bus.alu_op, 3'b011);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_retired", bus.retired, 0);
    check_eq("arst_aluop", bus.alu_op, 3'b010);
    check_eq("arst_strobes", {bus.imem_req, bus.ir_load, bus.rf_wr_enable, bus.pc_enable}, 0);
    @(negedge clock);
    check_eq("arst_hold_rfwr", bus.rf_wr_enable, 0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("resume_irload", bus.ir_load, 1);
    bus.run = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("resume_wb_rfwr", bus.rf_wr_enable, 1);
    @(negedge clock);
    check_eq("resume_retired", bus.retired, 1);

    // Counter wrap: preload 0xFFFF, retire one addi
    force dut.retired_q = 16'hFFFF;
    @(negedge clock);
    release dut.retired_q;
    check_eq("wrap_preload", bus.retired, 16'hFFFF);
    bus.inst = InstAddi;
    bus.run  = 1'b1;
    @(negedge clock);
    bus.run = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("addi_exec_aluop", bus.alu_op, 3'b010);
    check_eq("addi_exec_ctrl", {bus.alu_src2, bus.rd_src, bus.zext}, 3'b110);
    @(negedge clock);
    check_eq("wrap_wb_rfwr", bus.rf_wr_enable, 1);
    check_eq("wrap_wb_retired", bus.retired, 16'hFFFF);
    @(negedge clock);
    check_eq("wrap_retired", bus.retired, 16'h0000);
    check_eq("wrap_idle_busy", bus.busy, 0);

    // Illegal lw: HALT, sticky except, no writes
    bus.inst = InstLw;
    bus.run  = 1'b1;
    @(negedge clock);
    check_eq("lw_irload", bus.ir_load, 1);
    check_eq("lw_fetch_except", bus.except, 0);
    @(negedge clock);
    check_eq("lw_decode_except", bus.except, 0);
    @(negedge clock);
    check_eq("lw_halt_except", bus.except, 1);
    check_eq("lw_halt_busy", bus.busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq($sformatf("halt_hold_%0d", i),
               {bus.except, bus.rf_wr_enable, bus.pc_enable, bus.imem_req, bus.ir_load,
                bus.busy}, 6'b100000);
    end
    check_eq("halt_retired", bus.retired, 0);
    reset = 1'b0;
    #1;
    check_eq("halt_rst_except", bus.except, 0);
    @(negedge clock);
    reset   = 1'b1;
    bus.run = 1'b0;
    @(negedge clock);
    check_eq("post_halt_busy", bus.busy, 0);
    check_eq("post_halt_except", bus.except, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
